md_iter_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the execute stage. It replaces the fixed 32-bit divider with a single engine that serves MUL/MULU/DIV/DIVU through one start/done handshake, configurable width and bits-per-cycle. It supports cancellation on pipeline flush and reports divide-by-zero. The pipeline holds execute stalled while busy is high; results go to the HI/LO write path in memory stage.

---
 rtl/md_iter_unit_pkg.sv | 20 ++
 rtl/md_iter_unit_step.sv | 42 ++++
 rtl/md_iter_unit.sv | 140 ++++++++++++++
 tb/tb_md_iter_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_iter_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM state
// encodings, operation select values and the iteration counter width helper.
package md_iter_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREP   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } md_state_t;

    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    // Counter must hold WIDTH/STEP itself, hence the +1.
    function automatic int cnt_width(input int width, input int step);
        return $clog2(width / step + 1);
    endfunction

endpackage

// File: rtl/md_iter_unit_step.sv
// One radix-2 iteration: restoring shift-subtract for divide, shift-add over
// the {hi, lo} accumulator for multiply. Chained STEP times per clock.
module md_step
    import md_iter_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] sum;

    // Divide: partial remainder in hi, dividend/quotient shifting through lo.
    // Multiply: multiplier consumed from lo[0], product shifts down into lo.
    always_comb begin
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, b};
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        hi_next = hi;
        lo_next = lo;
        if (is_div == MD_DIV) begin
            if (!diff[WIDTH]) begin
                hi_next = diff[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/md_iter_unit.sv
// Iterative multiply/divide engine with start/done handshake, flush cancel
// and divide-by-zero reporting. Magnitudes are iterated; signs fixed at the end.
module md_iter_unit
    import md_iter_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic             is_div,
    input  logic             is_sign,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);

    localparam int ITERS = WIDTH / STEP;
    localparam int CNT_W = cnt_width(WIDTH, STEP);

    md_state_t state, state_next;

    logic [CNT_W-1:0]            cnt;
    logic [WIDTH-1:0]            a_r, b_r, acc_hi, acc_lo;
    logic                        op_div, op_sign, neg_q, neg_r;
    logic                        accept, div_by_zero, fin_we;
    logic [STEP:0][WIDTH-1:0]    chain_hi, chain_lo;
    logic [WIDTH-1:0]            fin_hi, fin_lo;
    logic [2*WIDTH-1:0]          prod;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    assign accept      = (state == IDLE) && start && !cancel;
    assign div_by_zero = (op_div == MD_DIV) && (b_r == '0);
    assign fin_we      = (state_next == FINISH);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and handshake outputs; cancel overrides everything outside IDLE
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == FINISH);
        case (state)
            IDLE:    if (start && !cancel) state_next = PREP;
            PREP:    if (cancel)           state_next = IDLE;
                     else if (div_by_zero) state_next = FINISH;
                     else                  state_next = RUN;
            RUN:     if (cancel)                  state_next = IDLE;
                     else if (cnt == CNT_W'(1))   state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign chain_hi[0] = acc_hi;
    assign chain_lo[0] = acc_lo;

    for (genvar i = 0; i < STEP; i++) begin : g_step
        md_step #(.WIDTH(WIDTH)) u_step (
            .is_div  (op_div),
            .hi      (chain_hi[i]),
            .lo      (chain_lo[i]),
            .b       (b_r),
            .hi_next (chain_hi[i+1]),
            .lo_next (chain_lo[i+1])
        );
    end

    // Final result: sign fix-up of the last iteration, or the divide-by-zero pattern
    always_comb begin
        prod   = {chain_hi[STEP], chain_lo[STEP]};
        fin_hi = chain_hi[STEP];
        fin_lo = chain_lo[STEP];
        if (state == PREP) begin
            fin_hi = a_r;
            fin_lo = '1;
        end else if (op_div == MD_DIV) begin
            if (neg_q) fin_lo = -chain_lo[STEP];
            if (neg_r) fin_hi = -chain_hi[STEP];
        end else begin
            if (neg_q) prod = -prod;
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end
    end

    // Operand capture, magnitude preparation and accumulator iteration
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r     <= opa;
            b_r     <= opb;
            op_div  <= is_div;
            op_sign <= is_sign;
        end
        if (state == PREP) begin
            acc_hi <= '0;
            acc_lo <= abs_val(a_r, op_sign);
            b_r    <= abs_val(b_r, op_sign);
            neg_q  <= op_sign & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
            neg_r  <= op_sign & a_r[WIDTH-1];
        end
        if (state == RUN) begin
            acc_hi <= chain_hi[STEP];
            acc_lo <= chain_lo[STEP];
        end
    end

    // Iteration counter and held results; results change only on entry to FINISH
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            result_hi <= '0;
            result_lo <= '0;
            div_zero  <= 1'b0;
        end else begin
            if (accept) div_zero <= 1'b0;
            if (state == PREP)     cnt <= CNT_W'(ITERS);
            else if (state == RUN) cnt <= cnt - CNT_W'(1);
            if (fin_we) begin
                result_hi <= fin_hi;
                result_lo <= fin_lo;
                div_zero  <= (state == PREP);
            end
        end
    end

endmodule

// File: tb/tb_md_iter_unit.sv
// Bench for md_iter_unit: default 32/1 instance and a 16/4 instance.
module tb_md_iter_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    logic        start_a = 0, cancel_a = 0, is_div_a = 0, is_sign_a = 0;
    logic [31:0] opa_a = 0, opb_a = 0;
    logic        busy_a, done_a, div_zero_a;
    logic [31:0] result_hi_a, result_lo_a;

    logic        start_b = 0, cancel_b = 0, is_div_b = 0, is_sign_b = 0;
    logic [15:0] opa_b = 0, opb_b = 0;
    logic        busy_b, done_b, div_zero_b;
    logic [15:0] result_hi_b, result_lo_b;

    md_iter_unit #(.WIDTH(32), .STEP(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cancel(cancel_a),
        .is_div(is_div_a), .is_sign(is_sign_a), .opa(opa_a), .opb(opb_a),
        .busy(busy_a), .done(done_a), .div_zero(div_zero_a),
        .result_hi(result_hi_a), .result_lo(result_lo_a)
    );

    md_iter_unit #(.WIDTH(16), .STEP(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cancel(cancel_b),
        .is_div(is_div_b), .is_sign(is_sign_b), .opa(opa_b), .opb(opb_b),
        .busy(busy_b), .done(done_b), .div_zero(div_zero_b),
        .result_hi(result_hi_b), .result_lo(result_lo_b)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    typedef struct {
        logic        b16;
        logic        div;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int done_cnt_a = 0, done_cyc_a = 0;
    int done_cnt_b = 0, done_cyc_b = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model built on 64-bit native arithmetic
    function automatic void model(input int w, input logic div, input logic sgn,
                                  input logic [31:0] a_in, input logic [31:0] b_in,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dz);
        logic [63:0] mask, pr;
        longint sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'({32'b0, a_in} & mask);
        sb = longint'({32'b0, b_in} & mask);
        if (sgn && a_in[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b_in[w-1]) sb = sb - (longint'(1) << w);
        dz = 1'b0;
        if (!div) begin
            pr = 64'(sa * sb);
            lo = 32'(pr & mask);
            hi = 32'((pr >> w) & mask);
        end else if (sb == 0) begin
            dz = 1'b1;
            lo = 32'(mask);
            hi = 32'({32'b0, a_in} & mask);
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = 32'(64'(q) & mask);
            hi = 32'(64'(r) & mask);
        end
    endfunction

    // Scoreboard pop on each done pulse
    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            done_cnt_a++;
            done_cyc_a = cyc;
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_done: got done=1 expected no done (hi=%h lo=%h)", result_hi_a, result_lo_a);
            end else begin
                ea = q_a.pop_front();
                chk("a_hi", result_hi_a, ea.hi);
                chk("a_lo", result_lo_a, ea.lo);
                chk("a_dz", {31'b0, div_zero_a}, {31'b0, ea.dz});
            end
        end
        if (done_b === 1'b1) begin
            done_cnt_b++;
            done_cyc_b = cyc;
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_done: got done=1 expected no done (hi=%h lo=%h)", result_hi_b, result_lo_b);
            end else begin
                eb = q_b.pop_front();
                chk("b_hi", {16'h0, result_hi_b}, eb.hi);
                chk("b_lo", {16'h0, result_lo_b}, eb.lo);
                chk("b_dz", {31'b0, div_zero_b}, {31'b0, eb.dz});
            end
        end
    end

    task automatic op_a(input logic div, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                        input int lat, input string name);
        int c0, n, i;
        exp_t e;
        e.hi = hi; e.lo = lo; e.dz = dz;
        q_a.push_back(e);
        @(negedge clk);
        start_a = 1; is_div_a = div; is_sign_a = sgn; opa_a = a; opb_a = b;
        c0 = cyc; n = done_cnt_a;
        @(negedge clk);
        start_a = 0; opa_a = $urandom; opb_a = $urandom; is_div_a = ~div; is_sign_a = ~sgn;
        i = 0;
        while (done_cnt_a == n && i < 200) begin @(posedge clk); i++; end
        if (done_cnt_a == n) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
            q_a.delete();
        end else begin
            chk({name, "_lat"}, done_cyc_a - c0, lat);
        end
    endtask

    task automatic op_b(input logic div, input logic sgn, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                        input int lat, input string name);
        int c0, n, i;
        exp_t e;
        e.hi = hi; e.lo = lo; e.dz = dz;
        q_b.push_back(e);
        @(negedge clk);
        start_b = 1; is_div_b = div; is_sign_b = sgn; opa_b = a; opb_b = b;
        c0 = cyc; n = done_cnt_b;
        @(negedge clk);
        start_b = 0; opa_b = 16'($urandom); opb_b = 16'($urandom); is_div_b = ~div; is_sign_b = ~sgn;
        i = 0;
        while (done_cnt_b == n && i < 200) begin @(posedge clk); i++; end
        if (done_cnt_b == n) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
            q_b.delete();
        end else begin
            chk({name, "_lat"}, done_cyc_b - c0, lat);
        end
    endtask

    vec_t tbl[$];
    exp_t e_seq;
    int c0, n, i;

    initial begin
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'd100,        32'd7,        32'd2,        32'd14,       1'b0, 34});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 34});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h0,        32'h1,        1'b0, 34});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1,        1'b0, 34});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h1234,       32'h0,        32'h1234,     32'hFFFFFFFF, 1'b1, 2});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'd50,         32'd5,        32'd0,        32'd10,       1'b0, 34});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 32'hFFFFFFFD,   32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'hFFFFFFF9,   32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h10000,      32'h10000,    32'd1,        32'd0,        1'b0, 34});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'hFFFFFFFF,   32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 34});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        1'b0, 34});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 32'd5,          32'd0,        32'd0,        32'd0,        1'b0, 34});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 32'd1000,       32'd7,        32'd6,        32'd142,      1'b0, 6});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 32'hFFFF,       32'h2,        32'hFFFF,     32'hFFFE,     1'b0, 6});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 32'h8000,       32'hFFFF,     32'h0,        32'h8000,     1'b0, 6});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 32'hABCD,       32'h0,        32'hABCD,     32'hFFFF,     1'b1, 2});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 32'hFFFF,       32'hFFFF,     32'hFFFE,     32'h0001,     1'b0, 6});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hFF9C,       32'd7,        32'hFFFE,     32'hFFF2,     1'b0, 6});

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'b0, busy_a}, 32'd0);
        chk("rst_done", {31'b0, done_a}, 32'd0);
        chk("rst_dz",   {31'b0, div_zero_a}, 32'd0);
        chk("rst_hi",   result_hi_a, 32'd0);
        chk("rst_lo",   result_lo_a, 32'd0);
        chk("rst_b_lo", {16'h0, result_lo_b}, 32'd0);

        // Directed vectors
        foreach (tbl[k]) begin
            if (tbl[k].b16)
                op_b(tbl[k].div, tbl[k].sgn, tbl[k].a[15:0], tbl[k].b[15:0],
                     tbl[k].hi, tbl[k].lo, tbl[k].dz, tbl[k].lat, "vec_b");
            else
                op_a(tbl[k].div, tbl[k].sgn, tbl[k].a, tbl[k].b,
                     tbl[k].hi, tbl[k].lo, tbl[k].dz, tbl[k].lat, "vec_a");
        end

        // busy window, div_zero held after a zero divide and cleared by next start
        op_a(1'b1, 1'b0, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1, 2, "dz");
        e_seq.hi = 32'd2; e_seq.lo = 32'd14; e_seq.dz = 1'b0;
        q_a.push_back(e_seq);
        @(negedge clk);
        start_a = 1; is_div_a = 1; is_sign_a = 0; opa_a = 32'd100; opb_a = 32'd7;
        #1;
        chk("busy_c0", {31'b0, busy_a}, 32'd0);
        chk("dz_held", {31'b0, div_zero_a}, 32'd1);
        @(negedge clk);
        start_a = 0;
        chk("busy_c1", {31'b0, busy_a}, 32'd1);
        chk("dz_clear", {31'b0, div_zero_a}, 32'd0);
        repeat (33) @(negedge clk);
        chk("busy_c34", {31'b0, busy_a}, 32'd1);
        chk("done_c34", {31'b0, done_a}, 32'd1);
        @(negedge clk);
        chk("busy_c35", {31'b0, busy_a}, 32'd0);
        chk("done_c35", {31'b0, done_a}, 32'd0);

        // cancel mid-run keeps previous results and suppresses done
        op_a(1'b0, 1'b0, 32'h10000, 32'h10000, 32'd1, 32'd0, 1'b0, 34, "pre_cancel");
        n = done_cnt_a;
        @(negedge clk);
        start_a = 1; is_div_a = 1; is_sign_a = 0; opa_a = 32'd1000; opb_a = 32'd3;
        @(negedge clk);
        start_a = 0;
        repeat (9) @(negedge clk);
        cancel_a = 1;
        @(negedge clk);
        cancel_a = 0;
        chk("cancel_busy", {31'b0, busy_a}, 32'd0);
        repeat (40) @(negedge clk);
        chk("cancel_no_done", done_cnt_a, n);
        chk("cancel_hi", result_hi_a, 32'd1);
        chk("cancel_lo", result_lo_a, 32'd0);

        // start together with cancel in IDLE is dropped
        @(negedge clk);
        start_a = 1; cancel_a = 1; is_div_a = 1; opa_a = 32'd9; opb_a = 32'd3;
        @(negedge clk);
        start_a = 0; cancel_a = 0;
        chk("sc_busy", {31'b0, busy_a}, 32'd0);
        repeat (40) @(negedge clk);
        chk("sc_no_done", done_cnt_a, n);

        // start while busy is ignored
        e_seq.hi = 32'd0; e_seq.lo = 32'd100; e_seq.dz = 1'b0;
        q_a.push_back(e_seq);
        @(negedge clk);
        start_a = 1; is_div_a = 1; is_sign_a = 0; opa_a = 32'd1000; opb_a = 32'd10;
        c0 = cyc; n = done_cnt_a;
        @(negedge clk);
        start_a = 0;
        repeat (3) @(negedge clk);
        start_a = 1; is_div_a = 0; opa_a = 32'd7; opb_a = 32'd9;
        @(negedge clk);
        start_a = 0;
        i = 0;
        while (done_cnt_a == n && i < 200) begin @(posedge clk); i++; end
        chk("busy_start_lat", done_cyc_a - c0, 34);
        repeat (40) @(negedge clk);
        chk("busy_start_one_done", done_cnt_a, n + 1);

        // reset during RUN clears all outputs
        @(negedge clk);
        start_a = 1; is_div_a = 1; is_sign_a = 0; opa_a = 32'd1000; opb_a = 32'd3;
        @(negedge clk);
        start_a = 0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_busy", {31'b0, busy_a}, 32'd0);
        chk("mrst_done", {31'b0, done_a}, 32'd0);
        chk("mrst_dz",   {31'b0, div_zero_a}, 32'd0);
        chk("mrst_hi",   result_hi_a, 32'd0);
        chk("mrst_lo",   result_lo_a, 32'd0);
        rst = 1'b0;

        // randomised ops against the reference model
        for (int k = 0; k < 1000; k++) begin
            logic [31:0] a, b, hi, lo;
            logic d, s, dz;
            a = $urandom; b = $urandom;
            d = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: a = $urandom_range(0, 1000);
                default: ;
            endcase
            model(32, d, s, a, b, hi, lo, dz);
            op_a(d, s, a, b, hi, lo, dz, dz ? 2 : 34, "rand_a");
        end
        for (int k = 0; k < 1000; k++) begin
            logic [31:0] a, b, hi, lo;
            logic d, s, dz;
            a = {16'h0, 16'($urandom)}; b = {16'h0, 16'($urandom)};
            d = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin a = 32'h8000; b = 32'hFFFF; end
                default: ;
            endcase
            model(16, d, s, a, b, hi, lo, dz);
            op_b(d, s, a[15:0], b[15:0], hi, lo, dz, dz ? 2 : 6, "rand_b");
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
